// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_det_pkg
// Description : Elaboration-time helpers for the parameterised serial-pattern
//               detector: state width, pattern self-border length and the
//               KMP next-state function used to build the constant table.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_det_pkg;

    // Widest pattern the helpers are written for.
    localparam int c_MAX_LEN = 16;

    // Bits needed to hold a matched-prefix length 0..len.
    function automatic int st_width(input int len);
        return $clog2(len + 1);
    endfunction

    // Longest proper border of the whole pattern, i.e. the longest prefix
    // (shorter than the pattern) that is also a suffix. Pattern bit
    // len-1 is the first bit received.
    function automatic int border_len(input logic [15:0] pattern, input int len);
        int r;
        bit ok;
        r = 0;
        for (int k = 1; k < c_MAX_LEN; k++) begin
            if (k < len) begin
                ok = 1'b1;
                for (int i = 0; i < c_MAX_LEN; i++) begin
                    if (i < k) begin
                        if (pattern[len-1-i] != pattern[k-1-i]) begin
                            ok = 1'b0;
                        end
                    end
                end
                if (ok) begin
                    r = k;
                end
            end
        end
        return r;
    endfunction

    // Next matched-prefix length after appending bit b to the prefix of
    // length st: the longest suffix of (prefix ++ b) that is itself a
    // pattern prefix. Covers both the advance case (k = st+1) and fallback.
    function automatic int next_st(input logic [15:0] pattern, input int len,
                                   input int st, input logic b);
        int  r;
        int  j;
        bit  ok;
        logic sb;
        r = 0;
        for (int k = 1; k <= c_MAX_LEN; k++) begin
            if (k <= len && k <= st + 1) begin
                ok = 1'b1;
                for (int i = 0; i < c_MAX_LEN; i++) begin
                    if (i < k) begin
                        j  = st + 1 - k + i;
                        sb = (j == st) ? b : pattern[len-1-j];
                        if (sb != pattern[len-1-i]) begin
                            ok = 1'b0;
                        end
                    end
                end
                if (ok) begin
                    r = k;
                end
            end
        end
        return r;
    endfunction

endpackage : seq_det_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Saturating up-counter with synchronous clear. A clear that
//               coincides with an increment loads 1 so the event is kept.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q,
    output logic         sat
);

    logic [W-1:0] r_q;

    // Count register: reset, clear (keeping a same-edge event), saturating increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= inc ? W'(1) : '0;
        end else if (inc && !(&r_q)) begin
            r_q <= r_q + W'(1);
        end
    end

    assign q   = r_q;
    assign sat = &r_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
// Module      : seq_detector_param
// Description : Parameterised Moore serial-pattern detector. State is the
//               matched-prefix length; transitions come from a constant KMP
//               table built at elaboration. Counts matches in a saturating,
//               software-clearable counter.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int          LEN     = 4,
    parameter logic [15:0] PATTERN = 16'b1010,
    parameter bit          OVERLAP = 1'b1,
    parameter int          CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             clear_cnt,
    output logic             dout,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam int              c_ST_W    = st_width(LEN);
    localparam logic [c_ST_W-1:0] c_MATCH = c_ST_W'(LEN);
    // From MATCH, overlapping mode resumes from the pattern's own border;
    // non-overlapping mode behaves as if nothing had been seen.
    localparam int              c_RESTART = OVERLAP ? border_len(PATTERN, LEN) : 0;

    if (LEN < 2 || LEN > 16) begin : g_bad_len
        $error("seq_detector_param: LEN must be in 2..16");
    end
    if ((PATTERN >> LEN) != 16'd0) begin : g_bad_pat
        $error("seq_detector_param: PATTERN wider than LEN");
    end

    // Constant transition table indexed by [state][din].
    logic [c_ST_W-1:0] w_tbl [0:LEN][0:1];

    for (genvar s = 0; s <= LEN; s++) begin : g_row
        for (genvar b = 0; b < 2; b++) begin : g_col
            localparam int c_FROM = (s == LEN) ? c_RESTART : s;
            localparam int c_NXT  = next_st(PATTERN, LEN, c_FROM, (b != 0));
            assign w_tbl[s][b] = c_ST_W'(c_NXT);
        end
    end

    logic [c_ST_W-1:0] r_st;
    logic              r_dout;
    logic [c_ST_W-1:0] w_nxt;
    logic              w_hit;

    assign w_nxt = w_tbl[r_st][din];
    assign w_hit = din_valid && (w_nxt == c_MATCH);

    // State register and registered detect flag; both hold while din_valid is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_st   <= '0;
            r_dout <= 1'b0;
        end else if (din_valid) begin
            r_st   <= w_nxt;
            r_dout <= (w_nxt == c_MATCH);
        end
    end

    assign dout = r_dout;

    sat_counter #(
        .W   (CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_hit),
        .clr (clear_cnt),
        .q   (match_cnt),
        .sat (cnt_sat)
    );

endmodule : seq_detector_param
`default_nettype wire

// File: tb/tb_seq_detector_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_detector_param
// Description : Four detector configurations driven by shared stimulus;
//               expected outputs come from a sliding-window model and are
//               checked by a queue-based scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detector_param;

    localparam int c_N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic din = 1'b0;
    logic din_valid = 1'b0;
    logic clear_cnt = 1'b0;

    logic [3:0]      act_d;
    logic [3:0]      act_s;
    logic [3:0][7:0] act_c;
    logic [7:0]      cnt_a;
    logic [7:0]      cnt_b;
    logic [1:0]      cnt_c;
    logic [2:0]      cnt_d;

    // A: default; B: non-overlapping; C: 2-bit counter; D: 6-bit pattern.
    seq_detector_param #(.LEN(4), .PATTERN(16'b1010), .OVERLAP(1'b1), .CNT_W(8)) u_a (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clear_cnt(clear_cnt),
        .dout(act_d[0]), .match_cnt(cnt_a), .cnt_sat(act_s[0]));
    seq_detector_param #(.LEN(4), .PATTERN(16'b1010), .OVERLAP(1'b0), .CNT_W(8)) u_b (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clear_cnt(clear_cnt),
        .dout(act_d[1]), .match_cnt(cnt_b), .cnt_sat(act_s[1]));
    seq_detector_param #(.LEN(4), .PATTERN(16'b1010), .OVERLAP(1'b1), .CNT_W(2)) u_c (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clear_cnt(clear_cnt),
        .dout(act_d[2]), .match_cnt(cnt_c), .cnt_sat(act_s[2]));
    seq_detector_param #(.LEN(6), .PATTERN(16'b110110), .OVERLAP(1'b1), .CNT_W(3)) u_d (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clear_cnt(clear_cnt),
        .dout(act_d[3]), .match_cnt(cnt_d), .cnt_sat(act_s[3]));

    assign act_c[0] = cnt_a;
    assign act_c[1] = cnt_b;
    assign act_c[2] = {6'd0, cnt_c};
    assign act_c[3] = {5'd0, cnt_d};

    // Model configuration, mirrors the instance parameters above.
    int          m_len [c_N] = '{4, 4, 4, 6};
    logic [15:0] m_pat [c_N] = '{16'b1010, 16'b1010, 16'b1010, 16'b110110};
    bit          m_ov  [c_N] = '{1'b1, 1'b0, 1'b1, 1'b1};
    int          m_cw  [c_N] = '{8, 8, 2, 3};

    // Model state: recent valid bits and how many of them count toward a match.
    logic [15:0] h_bits [c_N];
    int          h_cnt  [c_N];
    bit          m_dout [c_N];
    int          m_cnt  [c_N];

    typedef struct packed {
        logic [3:0]      d;
        logic [3:0]      s;
        logic [3:0][7:0] c;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input int idx, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s[%0d] got %0d expected %0d at %0t", name, idx, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge with the given inputs.
    task automatic model_step(input int i, input logic r, input logic d,
                              input logic v, input logic c);
        bit   hit;
        int   max;
        logic [15:0] mask;
        max  = (1 << m_cw[i]) - 1;
        mask = 16'((32'd1 << m_len[i]) - 1);
        hit  = 1'b0;
        if (r) begin
            h_bits[i] = '0;
            h_cnt[i]  = 0;
            m_dout[i] = 1'b0;
            m_cnt[i]  = 0;
        end else begin
            if (v) begin
                h_bits[i] = {h_bits[i][14:0], d};
                h_cnt[i]  = h_cnt[i] + 1;
                hit = (h_cnt[i] >= m_len[i]) && ((h_bits[i] & mask) == m_pat[i]);
                m_dout[i] = hit;
                if (hit && !m_ov[i]) begin
                    h_cnt[i] = 0;
                end
            end
            if (c) begin
                m_cnt[i] = hit ? 1 : 0;
            end else if (hit && m_cnt[i] < max) begin
                m_cnt[i] = m_cnt[i] + 1;
            end
        end
    endtask

    // Drive one cycle of inputs and queue the expected post-edge outputs.
    task automatic cycle(input logic r, input logic d, input logic v, input logic c);
        exp_t e;
        @(negedge clk);
        rst       = r;
        din       = d;
        din_valid = v;
        clear_cnt = c;
        for (int i = 0; i < c_N; i++) begin
            model_step(i, r, d, v, c);
            e.d[i] = m_dout[i];
            e.c[i] = 8'(m_cnt[i]);
            e.s[i] = (m_cnt[i] == (1 << m_cw[i]) - 1);
        end
        sb_q.push_back(e);
    endtask

    task automatic send_bits(input logic [31:0] bits, input int n);
        for (int k = n - 1; k >= 0; k--) begin
            cycle(1'b0, bits[k], 1'b1, 1'b0);
        end
    endtask

    // Scoreboard monitor: pop and compare just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            for (int i = 0; i < c_N; i++) begin
                chk("dout",      i, int'(act_d[i]), int'(mon_e.d[i]));
                chk("match_cnt", i, int'(act_c[i]), int'(mon_e.c[i]));
                chk("cnt_sat",   i, int'(act_s[i]), int'(mon_e.s[i]));
            end
        end
    end

    initial begin
        for (int i = 0; i < c_N; i++) begin
            h_bits[i] = '0;
            h_cnt[i]  = 0;
            m_dout[i] = 1'b0;
            m_cnt[i]  = 0;
        end

        // Reset, single match, then overlap continuation 1,0.
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        send_bits(32'b101010, 6);

        // Reset mid-pattern with a valid bit present, then a clean match.
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        send_bits(32'b101, 3);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        send_bits(32'b1010, 4);

        // Gapped stream with junk ones on invalid cycles; MATCH held afterwards.
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 3; k >= 0; k--) begin
            cycle(1'b0, k[0] ? 1'b1 : 1'b0, 1'b1, 1'b0);
            cycle(1'b0, 1'b1, 1'b0, 1'b0);
        end
        repeat (3) cycle(1'b0, 1'b1, 1'b0, 1'b0);

        // Saturation of the 2-bit counter, then clear on a matching edge.
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        send_bits(32'b1010101010, 10);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        send_bits(32'b10, 2);

        // Six-bit pattern with an overlapping second occurrence.
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        send_bits(32'b110110110, 9);

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
                  1'($urandom),
                  ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 0, sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_seq_detector_param
`default_nettype wire
